// File: rtl/usb_bulkin_arbiter_pkg.sv
// Shared constants for the USB bulk-IN arbiter: packet size, FSM encodings, grant codes.
package usb_bulkin_arbiter_pkg;

  localparam int unsigned USB_HS_BULK_MAX = 512;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage

// File: rtl/usb_bulkin_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker. Holds the last-served index; on a tie the
// other requester wins. Grant output is combinational from the request vector.
module usb_bulkin_arbiter_rr_arbiter2
  import usb_bulkin_arbiter_pkg::*;
#(
  parameter int unsigned First = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic [1:0] grant_o
);

  logic last_q;

  // Last-served pointer; reset to the opposite of First so First wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= (First == 0) ? 1'b1 : 1'b0;
    end else if (update_i) begin
      last_q <= served_i;
    end
  end

  // Pick a single requester, favouring the one not served last.
  always_comb begin
    grant_o = GRANT_NONE;
    case (req_i)
      2'b01:   grant_o = GRANT_S0;
      2'b10:   grant_o = GRANT_S1;
      2'b11:   grant_o = last_q ? GRANT_S0 : GRANT_S1;
      default: grant_o = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/usb_bulkin_arbiter.sv
// Packet-granular round-robin arbiter sharing the USB bulk-IN byte stream between
// the DDR3 read-back source (s0) and the telemetry source (s1). Long frames are
// cut into packets of at most MAX_LENGTH bytes, re-arbitrating at each cut.
module usb_bulkin_arbiter
  import usb_bulkin_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LENGTH = USB_HS_BULK_MAX,
  parameter int unsigned CBITS      = 11,
  parameter int unsigned FIRST      = 0
) (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic       s0_tlast,
  input  logic [7:0] s0_tdata,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic       s1_tlast,
  input  logic [7:0] s1_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic [7:0] m_tdata,
  output logic [1:0] grant_o,
  output logic       chunk_o
);

  logic [0:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             chunk_q, chunk_d;
  logic [1:0]       pick;
  logic             sel_tvalid, sel_tlast;
  logic             at_max, beat, end_beat;

  usb_bulkin_arbiter_rr_arbiter2 #(
    .First (FIRST)
  ) u_rr (
    .clk_i    (clock),
    .rst_ni   (arst_n),
    .req_i    ({s1_tvalid, s0_tvalid}),
    .update_i (end_beat),
    .served_i (grant_q[1]),
    .grant_o  (pick)
  );

  // Zero-latency pass-through of the granted source; everything idle when ungranted.
  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    m_tdata    = 8'h00;
    s0_tready  = 1'b0;
    s1_tready  = 1'b0;
    case (grant_q)
      GRANT_S0: begin
        sel_tvalid = s0_tvalid;
        sel_tlast  = s0_tlast;
        m_tdata    = s0_tdata;
        s0_tready  = m_tready;
      end
      GRANT_S1: begin
        sel_tvalid = s1_tvalid;
        sel_tlast  = s1_tlast;
        m_tdata    = s1_tdata;
        s1_tready  = m_tready;
      end
      default: ;
    endcase
  end

  assign at_max   = (count_q == CBITS'(MAX_LENGTH - 1));
  assign m_tvalid = sel_tvalid;
  // A source tlast on the max-size byte counts as a natural end (no chunk pulse).
  assign m_tlast  = sel_tlast | (at_max & (state_q == ST_XFER));
  assign beat     = (state_q == ST_XFER) & sel_tvalid & m_tready;
  assign end_beat = beat & m_tlast;
  assign grant_o  = grant_q;
  assign chunk_o  = chunk_q;

  // Next-state: grant in IDLE, count beats in XFER, drop back to IDLE on the last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    chunk_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick != GRANT_NONE) begin
          grant_d = pick;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (end_beat) begin
          grant_d = GRANT_NONE;
          count_d = '0;
          state_d = ST_IDLE;
          chunk_d = ~sel_tlast;
        end else if (beat) begin
          count_d = count_q + CBITS'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GRANT_NONE;
        count_d = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_NONE;
      count_q <= '0;
      chunk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      chunk_q <= chunk_d;
    end
  end

endmodule

// File: tb/tb_usb_bulkin_arbiter.sv
// Self-checking bench for usb_bulkin_arbiter: queue-based source drivers, a
// packet-level reference model checked every cycle, and literal packet logs.
module tb_usb_bulkin_arbiter;

  localparam int MaxLen = 512;

  logic       clock = 1'b0;
  logic       arst_n;
  logic       s0_tvalid, s0_tready, s0_tlast;
  logic [7:0] s0_tdata;
  logic       s1_tvalid, s1_tready, s1_tlast;
  logic [7:0] s1_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata;
  logic [1:0] grant_o;
  logic       chunk_o;

  usb_bulkin_arbiter #(
    .MAX_LENGTH (MaxLen),
    .CBITS      (11),
    .FIRST      (0)
  ) dut (
    .clock     (clock),
    .arst_n    (arst_n),
    .s0_tvalid (s0_tvalid),
    .s0_tready (s0_tready),
    .s0_tlast  (s0_tlast),
    .s0_tdata  (s0_tdata),
    .s1_tvalid (s1_tvalid),
    .s1_tready (s1_tready),
    .s1_tlast  (s1_tlast),
    .s1_tdata  (s1_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tdata   (m_tdata),
    .grant_o   (grant_o),
    .chunk_o   (chunk_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } beat_t;

  // Driver queues (what each source still has to hand over) and model queues
  // (what the output must still carry from each source, in order).
  beat_t drv0[$], drv1[$], exp0[$], exp1[$];

  int checks, errors;
  int m_cur;     // -1 idle, else source currently owning the output
  int m_cnt;     // bytes of the current packet already sent
  int m_last;    // last served source
  bit m_chunk;   // chunk pulse expected on the next idle cycle
  int pkt_src[$], pkt_len[$];
  int run_len, chunk_seen, g0_cycles;
  int unsigned valid_pct, ready_pct;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic load_frame(input int src, input int len, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = rnd ? 8'($urandom) : 8'(i);
      b.l = (i == len - 1);
      if (src == 0) begin
        drv0.push_back(b);
        exp0.push_back(b);
      end else begin
        drv1.push_back(b);
        exp1.push_back(b);
      end
    end
  endtask

  task automatic clear_log();
    pkt_src.delete();
    pkt_len.delete();
    run_len    = 0;
    chunk_seen = 0;
    g0_cycles  = 0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_chunk", chunk_o, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s0_tready", s0_tready, 0);
    chk("rst_s1_tready", s1_tready, 0);
    drv0.delete(); drv1.delete(); exp0.delete(); exp1.delete();
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = 8'h00;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = 8'h00;
    m_cur = -1; m_cnt = 0; m_last = 1; m_chunk = 1'b0;
    clear_log();
    repeat (2) @(posedge clock);
    #1 arst_n = 1'b1;
  endtask

  // One clock: check outputs against the model at the falling edge, advance the
  // model, then after the rising edge let the drivers react to handshakes.
  task automatic step();
    bit    acc0, acc1, gv, exp_last;
    int    g;
    beat_t head;
    @(negedge clock);
    acc0 = s0_tvalid && s0_tready;
    acc1 = s1_tvalid && s1_tready;
    if (grant_o == 2'b01) g0_cycles++;
    if (chunk_o) chunk_seen++;
    if (m_tvalid && m_tready) begin
      run_len++;
      if (m_tlast) begin
        pkt_src.push_back((grant_o == 2'b10) ? 1 : 0);
        pkt_len.push_back(run_len);
        run_len = 0;
      end
    end
    if (m_cur < 0) begin
      chk("idle_grant", grant_o, 0);
      chk("idle_m_tvalid", m_tvalid, 0);
      chk("idle_s0_tready", s0_tready, 0);
      chk("idle_s1_tready", s1_tready, 0);
      chk("idle_chunk", chunk_o, int'(m_chunk));
      m_chunk = 1'b0;
      if (s0_tvalid && s1_tvalid) m_cur = 1 - m_last;
      else if (s0_tvalid) m_cur = 0;
      else if (s1_tvalid) m_cur = 1;
    end else begin
      g  = m_cur;
      gv = (g == 0) ? s0_tvalid : s1_tvalid;
      chk("xfer_grant", grant_o, 1 << g);
      chk("xfer_chunk", chunk_o, 0);
      chk("xfer_m_tvalid", m_tvalid, int'(gv));
      chk("xfer_granted_tready", (g == 0) ? s0_tready : s1_tready, m_tready);
      chk("xfer_other_tready", (g == 0) ? s1_tready : s0_tready, 0);
      if (gv) begin
        if ((g == 0 && exp0.size() == 0) || (g == 1 && exp1.size() == 0)) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          head     = (g == 0) ? exp0[0] : exp1[0];
          exp_last = head.l || (m_cnt == MaxLen - 1);
          chk("m_tdata", m_tdata, head.d);
          chk("m_tlast", m_tlast, int'(exp_last));
          if (m_tready) begin
            if (g == 0) void'(exp0.pop_front());
            else void'(exp1.pop_front());
            m_cnt++;
            if (exp_last) begin
              m_last  = g;
              m_cur   = -1;
              m_cnt   = 0;
              m_chunk = !head.l;
            end
          end
        end
      end
    end
    @(posedge clock);
    #1;
    if (acc0) void'(drv0.pop_front());
    if (acc1) void'(drv1.pop_front());
    // A presented byte is held until accepted; bubbles only between bytes.
    if (!(s0_tvalid && !acc0)) begin
      if (drv0.size() > 0 && $urandom_range(99) < valid_pct) begin
        s0_tvalid = 1'b1; s0_tdata = drv0[0].d; s0_tlast = drv0[0].l;
      end else begin
        s0_tvalid = 1'b0; s0_tdata = 8'h00; s0_tlast = 1'b0;
      end
    end
    if (!(s1_tvalid && !acc1)) begin
      if (drv1.size() > 0 && $urandom_range(99) < valid_pct) begin
        s1_tvalid = 1'b1; s1_tdata = drv1[0].d; s1_tlast = drv1[0].l;
      end else begin
        s1_tvalid = 1'b0; s1_tdata = 8'h00; s1_tlast = 1'b0;
      end
    end
    m_tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (!(exp0.size() == 0 && exp1.size() == 0 && m_cur < 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", int'(n < budget), 1);
    repeat (2) step();
  endtask

  task automatic chk_pkts(input string name, input int n, input int es[4], input int el[4]);
    chk({name, "_npkts"}, pkt_len.size(), n);
    for (int i = 0; i < n && i < 4; i++) begin
      if (i < pkt_len.size()) begin
        chk({name, "_src"}, pkt_src[i], es[i]);
        chk({name, "_len"}, pkt_len[i], el[i]);
      end
    end
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    valid_pct = 100; ready_pct = 100; m_tready = 1'b1;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = 8'h00;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = 8'h00;
    do_reset();

    // Single 10-byte frame from s0.
    clear_log();
    load_frame(0, 10, 1'b0);
    run_until_idle(200);
    chk_pkts("t1", 1, '{0, 0, 0, 0}, '{10, 0, 0, 0});
    chk("t1_grant01_cycles", g0_cycles, 10);
    chk("t1_chunks", chunk_seen, 0);

    // Both sources busy from reset: strict alternation starting with s0.
    do_reset();
    load_frame(0, 4, 1'b1); load_frame(0, 4, 1'b1);
    load_frame(1, 4, 1'b1); load_frame(1, 4, 1'b1);
    run_until_idle(200);
    chk_pkts("t2", 4, '{0, 1, 0, 1}, '{4, 4, 4, 4});
    chk("t2_chunks", chunk_seen, 0);

    // 1200-byte frame split at the max packet size.
    clear_log();
    load_frame(0, 1200, 1'b1);
    run_until_idle(3000);
    chk_pkts("t3", 3, '{0, 0, 0, 0}, '{512, 512, 176, 0});
    chk("t3_chunks", chunk_seen, 2);

    // Same, with s1 interleaving between chunks.
    clear_log();
    load_frame(0, 1200, 1'b1);
    repeat (50) step();
    load_frame(1, 3, 1'b1);
    run_until_idle(3000);
    chk_pkts("t4", 4, '{0, 1, 0, 0}, '{512, 3, 512, 176});
    chk("t4_chunks", chunk_seen, 2);

    // Frame of exactly max size: one packet, natural end, no chunk pulse.
    clear_log();
    load_frame(1, 512, 1'b1);
    run_until_idle(1000);
    chk_pkts("t5", 1, '{1, 0, 0, 0}, '{512, 0, 0, 0});
    chk("t5_chunks", chunk_seen, 0);

    // Random lengths, source bubbles and output back-pressure.
    valid_pct = 70; ready_pct = 50;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      load_frame(0, int'($urandom_range(1, 700)), 1'b1);
      load_frame(1, int'($urandom_range(1, 700)), 1'b1);
    end
    run_until_idle(40000);
    for (int i = 0; i < pkt_len.size(); i++) chk("t6_len_le_max", int'(pkt_len[i] <= MaxLen), 1);

    // Reset in the middle of a packet.
    load_frame(0, 300, 1'b1);
    load_frame(1, 300, 1'b1);
    n = 0;
    while (!(m_cur >= 0 && m_cnt >= 5) && n < 500) begin
      step();
      n++;
    end
    chk("t6_midpkt_reached", int'(m_cur >= 0), 1);
    chk("t6_grant_before_rst", int'(grant_o != 2'b00), 1);
    #2;
    do_reset();

    // After reset the FIRST source wins the first tie.
    valid_pct = 100; ready_pct = 100;
    load_frame(0, 5, 1'b1);
    load_frame(1, 5, 1'b1);
    run_until_idle(200);
    chk_pkts("t7", 2, '{0, 1, 0, 0}, '{5, 5, 0, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_bulkin_arbiter.md
Name: usb_bulkin_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single USB bulk-IN endpoint data-path (8-bit AXI-Stream into the usb_ulpi_core 'blkx' input) between two sources.
- Source 0 is the DDR3 read-back stream (ddr3_top m_*); source 1 is the telemetry stream (ddr3_top tele_*).
- Sits in the USB clock domain.
- Enforces the USB max-packet size by splitting long source frames into chunks of at most MAX_LENGTH bytes and re-arbitrating at every chunk boundary.

Parameters:
- MAX_LENGTH, 512, maximum bytes per output packet (USB HS bulk max); legal range 8..2048.
- CBITS, 11, chunk byte-counter width; must satisfy 2^CBITS >= MAX_LENGTH.
- FIRST, 0, source favoured by round-robin after reset (0 or 1).

Ports:
- clock  in  1  USB/ULPI 60 MHz clock
- arst_n  in  1  asynchronous active-low reset
- s0_tvalid  in  1  DDR3 read-back valid
- s0_tready  out  1  DDR3 read-back ready
- s0_tlast  in  1  DDR3 read-back end-of-frame
- s0_tdata  in  8  DDR3 read-back byte
- s1_tvalid  in  1  telemetry valid
- s1_tready  out  1  telemetry ready
- s1_tlast  in  1  telemetry end-of-frame
- s1_tdata  in  8  telemetry byte
- m_tvalid  out  1  to USB bulk-IN valid
- m_tready  in  1  from USB bulk-IN ready
- m_tlast  out  1  end of USB packet
- m_tdata  out  8  USB packet byte
- grant_o  out  2  one-hot current grant; 2'b00 when idle
- chunk_o  out  1  one-cycle pulse when a packet end is forced by MAX_LENGTH rather than source tlast

Behaviour:
- Reset:
  - clock and arst_n are the only clock/reset; reset is asynchronous, active-low.
  - Outputs while in reset: grant_o=00, chunk_o=0, state=IDLE, count=0, last-served pointer = ~FIRST (so FIRST wins the first tie).
  - m_tvalid, s0_tready and s1_tready are 0 whenever grant_o=00.
- States:
  - IDLE: grant_o=00. If any sN_tvalid=1, register a grant and go to XFER.
    - Both valid: grant the source not last served.
    - One valid: grant it.
  - XFER: transparent combinational pass-through from the granted source. m_tvalid=sG_tvalid, sG_tready=m_tready, m_tdata=sG_tdata. The non-granted tready is held 0.
- Zero data-path latency. Exactly one dead cycle (IDLE) between consecutive packets.
- Counting and termination:
  - count increments on each m_tvalid && m_tready in XFER.
  - m_tlast = sG_tlast | (count == MAX_LENGTH-1).
  - On a beat with m_tlast=1: last-served <= G, count <= 0, state <= IDLE.
  - If sG_tlast=0 on that beat, chunk_o pulses the following cycle.
  - A chunked source keeps its remaining bytes pending. It re-enters arbitration as a new request, so the other source may interleave between chunks.
- Stalls and ordering:
  - Source tvalid deasserting mid-packet (bubble) holds the grant; there is no timeout.
  - m_tready=0 holds all state; outputs stay stable per AXI-S.
  - A source asserting tvalid while the other holds the grant sees tready=0 until that grant ends; no bytes are dropped or reordered.
- Boundaries:
  - A source tlast landing on byte MAX_LENGTH coincides with the forced end. It is treated as a natural end: chunk_o=0. No zero-length packet is generated (ZLP handling belongs to the USB core).
  - Single-byte frame (tvalid && tlast on the first beat): one-beat packet, back to IDLE.
  - count is CBITS wide and never wraps past MAX_LENGTH-1.
  - arst_n asserted mid-packet: immediate return to IDLE. The truncated packet is not resumed; sources must be reset alongside.

Decomposition:
- Shared package (usb_defs or equivalent): USB_HS_BULK_MAX=512, state encodings ST_IDLE/ST_XFER, grant one-hot constants.
- Sub-module rr_arbiter2: two-requester round-robin picker holding the last-served pointer. Inputs: req[1:0], update strobe, served index. Output: one-hot grant.
- Mux, counter and FSM stay in the top module.

Test Plan:
- Only s0 sends a 10-byte frame, m_tready=1 -> m carries bytes 0..9, m_tlast on byte 9, grant_o=01 for 10 cycles, then 00 for 1 cycle, chunk_o never set.
- s0 and s1 both valid from reset with FIRST=0, each sends two 4-byte frames -> output order s0,s1,s0,s1, each packet 4 beats, one dead cycle between packets.
- s0 sends a 1200-byte frame (MAX_LENGTH=512) while s1 idle -> packets of 512, 512, 176 bytes; chunk_o pulses after beats 512 and 1024; last packet ends on source tlast with no chunk pulse.
- Same 1200-byte s0 frame with s1 presenting a 3-byte frame during the first chunk -> sequence s0:512, s1:3, s0:512, s0:176; no s0 bytes lost (compare payload against a scoreboard).
- s1 frame of exactly 512 bytes -> single packet, m_tlast on byte 512, chunk_o=0, no zero-length packet emitted.
- Random m_tready (50%) and source bubbles, then arst_n pulsed low mid-packet -> all outputs 0 and grant_o=00 asynchronously; after release, FIRST source wins the first tie.
